lector_rom: RTL

LECTOR_ROM -- requirements
Module: lector_rom

---
 rtl/lector_rom.sv | 85 ++++++++
 1 files changed

// File: rtl/lector_rom.sv
// lector_rom: burst reader that streams words from a synchronous memory through a small FIFO
// with ready/valid handshake and a running 16-bit sum of delivered words.
module lector_rom #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int FIFO_D = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] cuenta,
  output logic [ADDR_W-1:0] direccion,
  output logic              rd_en,
  input  logic [DATA_W-1:0] dato_mem,
  output logic [DATA_W-1:0] dato,
  output logic              valido,
  input  logic              listo,
  output logic              ocupado,
  output logic              hecho,
  output logic [15:0]       suma
);
  localparam int PW = $clog2(FIFO_D);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_base, r_cuenta, r_issued;
  logic              r_inflight;
  logic [DATA_W-1:0] r_mem [FIFO_D];
  logic [PW-1:0]     r_wp, r_rp;
  logic [PW:0]       r_cnt;
  logic [15:0]       r_suma;
  logic              w_pop, w_last;
  assign valido    = r_cnt != '0;
  assign w_pop     = valido && listo;
  // A read is only issued when the FIFO has room for it and any word still in flight.
  assign rd_en     = r_state == READ && ({1'b0, r_cnt} + (PW+2)'(r_inflight)) < (PW+2)'(FIFO_D);
  assign w_last    = r_issued == r_cuenta - ADDR_W'(1);
  assign direccion = r_base + r_issued;
  assign dato      = valido ? r_mem[r_rp] : '0;
  assign ocupado   = r_state == READ || r_state == DRAIN;
  assign hecho     = r_state == DONE;
  assign suma      = r_suma;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = (cuenta == '0) ? DONE : READ;
      READ:    if (rd_en && w_last) w_next = DRAIN;
      DRAIN:   if (r_cnt == '0 && !r_inflight) w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_base     <= '0;
      r_cuenta   <= '0;
      r_issued   <= '0;
      r_inflight <= 1'b0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_cnt      <= '0;
      r_suma     <= '0;
    end else begin
      r_state    <= w_next;
      r_inflight <= rd_en;
      if (r_state == IDLE && start) begin
        r_base   <= base;
        r_cuenta <= cuenta;
        r_issued <= '0;
        r_suma   <= '0;
      end else if (rd_en) begin
        r_issued <= r_issued + ADDR_W'(1);
      end
      if (r_inflight) r_wp <= r_wp + PW'(1);
      if (w_pop) begin
        r_rp   <= r_rp + PW'(1);
        r_suma <= r_suma + 16'(dato);
      end
      r_cnt <= r_cnt + (PW+1)'(r_inflight) - (PW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (r_inflight) r_mem[r_wp] <= dato_mem;
  end
endmodule
